// File: rtl/wci_axi_pkg.sv
// ==========================================================================
// wci_axi_pkg : shared types and constants for the WCI AXI4-Lite slave
// Revision    : 1.0
// ==========================================================================
`default_nettype none

package wci_axi_pkg;

  typedef enum logic [2:0] {
    CTL_EXISTS      = 3'd0,
    CTL_INITIALIZED = 3'd1,
    CTL_OPERATING   = 3'd2,
    CTL_SUSPENDED   = 3'd3,
    CTL_UNUSABLE    = 3'd4
  } ctl_state_t;

  localparam logic [2:0] OP_INITIALIZE   = 3'd0;
  localparam logic [2:0] OP_START        = 3'd1;
  localparam logic [2:0] OP_STOP         = 3'd2;
  localparam logic [2:0] OP_RELEASE      = 3'd3;
  localparam logic [2:0] OP_TEST         = 3'd4;
  localparam logic [2:0] OP_BEFORE_QUERY = 3'd5;
  localparam logic [2:0] OP_AFTER_CONFIG = 3'd6;
  localparam logic [2:0] OP_STATUS       = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] RESULT_LEGAL   = 32'hC0DE_4201;
  localparam logic [31:0] RESULT_ILLEGAL = 32'hC0DE_4202;

endpackage

`default_nettype wire

// File: rtl/wci_ctl_fsm.sv
// ==========================================================================
// wci_ctl_fsm : worker control-state machine driven by control-space reads
// Revision    : 1.0
// ==========================================================================
`default_nettype none

module wci_ctl_fsm
  import wci_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  input  logic       op_valid,
  output ctl_state_t ctl_state,
  output logic       legal
);

  ctl_state_t state_q, state_d;
  ctl_state_t target;

  always_comb begin
    legal   = 1'b0;
    target  = state_q;
    case (op)
      OP_INITIALIZE: begin
        legal  = (state_q == CTL_EXISTS);
        target = CTL_INITIALIZED;
      end
      OP_START: begin
        legal  = (state_q inside {CTL_INITIALIZED, CTL_SUSPENDED});
        target = CTL_OPERATING;
      end
      OP_STOP: begin
        legal  = (state_q == CTL_OPERATING);
        target = CTL_SUSPENDED;
      end
      OP_RELEASE: begin
        legal  = (state_q inside {CTL_INITIALIZED, CTL_OPERATING, CTL_SUSPENDED});
        target = CTL_UNUSABLE;
      end
      OP_TEST, OP_BEFORE_QUERY, OP_AFTER_CONFIG:
        legal = (state_q inside {CTL_INITIALIZED, CTL_OPERATING, CTL_SUSPENDED});
      OP_STATUS:
        legal = 1'b1;
    endcase
    state_d = (op_valid && legal) ? target : state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CTL_EXISTS;
    else        state_q <= state_d;
  end

  assign ctl_state = state_q;

endmodule

`default_nettype wire

// File: rtl/wci_axi_slave.sv
// ==========================================================================
// wci_axi_slave : AXI4-Lite WCI target with config regs and control FSM.
// Optional: define WCI_SLV_ERR_EN to return SLVERR on illegal accesses.
// Revision      : 1.0
// ==========================================================================
`default_nettype none

module wci_axi_slave
  import wci_axi_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [2:0]            s_arprot,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic [2:0]            ctl_state,
  output logic                  ctl_operating,
  output logic [32*NREGS-1:0]   cfg_regs
);

  localparam int IDX_W  = $clog2(NREGS);
  localparam int HI_LSB = 2 + IDX_W;
  localparam int MSB    = ADDR_W - 1;

  // Nonzero bits between the register index and the space-select bit.
  function automatic logic aliased(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m      = a;
    m[MSB] = 1'b0;
    return (m >> HI_LSB) != '0;
  endfunction

  logic                        rdy_en_q;
  logic                        aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0]           aw_addr_q, aw_addr_d;
  logic [31:0]                 w_data_q, w_data_d;
  logic [3:0]                  w_strb_q, w_strb_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [NREGS-1:0][31:0]      regs_q, regs_d;
  logic                        rvalid_q, rvalid_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        aw_hs, w_hs, wr_exec, wr_err, ar_hs, op_valid, op_legal;
  logic [ADDR_W-1:0]           wr_addr;
  logic [31:0]                 wr_data;
  logic [3:0]                  wr_strb;
  logic [IDX_W-1:0]            wr_idx;
  logic [1:0]                  wr_resp;
  ctl_state_t                  fsm_state;

  // Write path: AW and W may arrive in either order; the write fires as soon as both are present.
  always_comb begin
    s_awready = rdy_en_q && !aw_full_q && !bvalid_q;
    s_wready  = rdy_en_q && !w_full_q && !bvalid_q;
    aw_hs     = s_awvalid && s_awready;
    w_hs      = s_wvalid && s_wready;
    wr_addr   = aw_full_q ? aw_addr_q : s_awaddr;
    wr_data   = w_full_q ? w_data_q : s_wdata;
    wr_strb   = w_full_q ? w_strb_q : s_wstrb;
    wr_idx    = wr_addr[2 +: IDX_W];
    wr_exec   = (aw_full_q || aw_hs) && (w_full_q || w_hs);
`ifdef WCI_SLV_ERR_EN
    wr_err    = !wr_addr[MSB] || aliased(wr_addr);
    wr_resp   = wr_err ? RESP_SLVERR : RESP_OKAY;
`else
    wr_err    = !wr_addr[MSB];
    wr_resp   = RESP_OKAY;
`endif
    aw_full_d = (aw_full_q || aw_hs) && !wr_exec;
    w_full_d  = (w_full_q || w_hs) && !wr_exec;
    aw_addr_d = aw_hs ? s_awaddr : aw_addr_q;
    w_data_d  = w_hs ? s_wdata : w_data_q;
    w_strb_d  = w_hs ? s_wstrb : w_strb_q;
    bvalid_d  = wr_exec || (bvalid_q && !s_bready);
    bresp_d   = wr_exec ? wr_resp : bresp_q;
    regs_d    = regs_q;
    if (wr_exec && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  assign s_arready = rdy_en_q && !rvalid_q;
  assign ar_hs     = s_arvalid && s_arready;
  assign op_valid  = ar_hs && !s_araddr[MSB];

  wci_ctl_fsm u_ctl_fsm (
    .clk       (CLK),
    .rst_n     (RST_N),
    .op        (s_araddr[4:2]),
    .op_valid  (op_valid),
    .ctl_state (fsm_state),
    .legal     (op_legal)
  );

  // Config reads sample regs_q, so a write firing in the same cycle is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q && !s_rready;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      if (s_araddr[MSB]) begin
        rdata_d = regs_q[s_araddr[2 +: IDX_W]];
`ifdef WCI_SLV_ERR_EN
        if (aliased(s_araddr)) rresp_d = RESP_SLVERR;
`endif
      end else begin
        if (s_araddr[4:2] == OP_STATUS) rdata_d = {29'b0, fsm_state};
        else                            rdata_d = op_legal ? RESULT_LEGAL : RESULT_ILLEGAL;
`ifdef WCI_SLV_ERR_EN
        if (!op_legal) rresp_d = RESP_SLVERR;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en_q  <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_en_q  <= 1'b1;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_bvalid      = bvalid_q;
  assign s_bresp       = bresp_q;
  assign s_rvalid      = rvalid_q;
  assign s_rdata       = rdata_q;
  assign s_rresp       = rresp_q;
  assign ctl_state     = fsm_state;
  assign ctl_operating = (fsm_state == CTL_OPERATING);
  assign cfg_regs      = regs_q;

  logic unused_ok;
  assign unused_ok = ^{s_awprot, s_arprot, s_awaddr, s_araddr, aw_addr_q};

endmodule

`default_nettype wire

// File: doc/wci_axi_slave.md
Name: wci_axi_slave

Overview:
- Downstream consumer of the OPED WCI::AXI AXI4-Lite master port (WCIM0).
- Terminates AXI4-Lite control traffic for one worker.
- Provides a configuration register file and the worker control-state machine (initialize/start/stop/release).
- Exports control state and register contents to the worker datapath.

Parameters:
- NREGS, 16, number of 32b configuration registers (power of 2, 2..256)
- ADDR_W, 32, AXI address width; bit ADDR_W-1 selects config (1) vs control (0) space

Ports:
- CLK  in  1  worker clock (oped_clk125 domain)
- RST_N  in  1  asynchronous active-low reset
- s_awvalid/s_awready  in/out  1/1  write address handshake
- s_awaddr  in  ADDR_W  write address
- s_awprot  in  3  ignored
- s_wvalid/s_wready  in/out  1/1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_bvalid/s_bready  out/in  1/1  write response handshake
- s_bresp  out  2  write response
- s_arvalid/s_arready  in/out  1/1  read address handshake
- s_araddr  in  ADDR_W  read address
- s_arprot  in  3  ignored
- s_rvalid/s_rready  out/in  1/1  read response handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- ctl_state  out  3  current control state
- ctl_operating  out  1  high when ctl_state==OPERATING
- cfg_regs  out  32*NREGS  flattened register file, reg i at [32i+:32]

Behaviour:
- Reset (async assert, sync release): all regs 0, ctl_state=EXISTS, all valid/ready outputs low, resp=OKAY, rdata=0.
- Address decode: config index=addr[2+:log2(NREGS)]; control op=addr[4:2]; addr[1:0] ignored; bits between index and MSB ignored.
- Write path:
  - AW and W are captured independently into 1-deep holding regs; awready/wready are high while the respective holding reg is empty and no B is pending.
  - When both are held: execute the write, assert bvalid the next cycle, free both holding regs.
  - bvalid is held until bready is sampled high.
- Write effect:
  - Config space: byte-wise update per wstrb; wstrb==0 is a legal no-op.
  - Control space: no effect, flagged as error.
- Read path:
  - arready is high when no R is pending.
  - On AR handshake, rvalid rises the next cycle with data registered (latency 1); held until rready.
  - Config read returns the register value.
- Control ops (a read of control space performs the op):
  - 0 INITIALIZE: EXISTS->INITIALIZED
  - 1 START: INITIALIZED|SUSPENDED->OPERATING
  - 2 STOP: OPERATING->SUSPENDED
  - 3 RELEASE: any state except EXISTS/UNUSABLE->UNUSABLE
  - 4 TEST, 5 BEFORE_QUERY, 6 AFTER_CONFIG: legal in INITIALIZED/OPERATING/SUSPENDED, no state change
  - 7 STATUS: always legal, returns {29'b0, ctl_state}
  - Legal op: rdata=32'hC0DE_4201. Illegal op: rdata=32'hC0DE_4202, state unchanged.
- State encodings: EXISTS=0, INITIALIZED=1, OPERATING=2, SUSPENDED=3, UNUSABLE=4. UNUSABLE is left only by reset.
- Config-space accesses are permitted in every state.
- Simultaneous same-cycle write execution and read to the same register: read returns the old value.
- Reads and writes are fully independent; one outstanding transaction of each.
- Reset mid-transaction: all pending responses are dropped, valids forced low.

Optional Feature:
- WCI_SLV_ERR_EN defined:
  - Illegal control op, control-space write, or config index >= NREGS (only when addr bits above the index are nonzero, i.e. aliasing) returns SLVERR (2'b10) on the corresponding bresp/rresp.
  - Data encodings are unchanged.
- WCI_SLV_ERR_EN undefined:
  - All responses are OKAY and aliasing is allowed (upper bits ignored).

Decomposition:
- Package wci_axi_pkg holds:
  - ctl_state_t enum and the op-code constants
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - result constants 32'hC0DE_4201/4202
- One sub-module, wci_ctl_fsm: inputs op and op_valid; outputs ctl_state and legal. It is instantiated inside the read path.

Test Plan:
- Reset, then write 0x8000_0004 data 0xA5A5_1234 strb 4'b1111, read it back -> bresp=00, rdata=0xA5A5_1234, R one cycle after AR.
- W presented 3 cycles before AW, strb 4'b0010 data 0x0000_FF00 to reg0 (held 0) -> reg0=0x0000_FF00, bvalid exactly one cycle after AW handshake.
- Read ops 0,1,2,1 at control space -> C0DE4201 x4, ctl_state 0->1->2->3->2, ctl_operating follows.
- From EXISTS, read op 1 (START) -> C0DE4202, state stays 0, rresp=10 only with WCI_SLV_ERR_EN.
- Hold bready=0 for 10 cycles -> bvalid stays high, awready/wready low, then one-cycle drain.
- Assert RST_N low mid-read with rvalid high -> rvalid drops immediately, ctl_state=0, cfg_regs=0.
